// File: rtl/jt51_interp.sv
// rtl/jt51_interp.sv - linear interpolating upsampler for the stereo FIR output
module jt51_interp #(
  parameter int data_width = 12,
  parameter int log2_ratio = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_in,
  input  logic signed [data_width-1:0] left_in,
  input  logic signed [data_width-1:0] right_in,
  input  logic                         cen_out,
  output logic signed [data_width-1:0] left_out,
  output logic signed [data_width-1:0] right_out,
  output logic                         sample_out,
  output logic                         overrun
);

  localparam int acc_w = data_width + log2_ratio;
  localparam int dlt_w = data_width + 1;
  localparam int cnt_w = (log2_ratio > 0) ? log2_ratio : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'((1 << log2_ratio) - 1);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_calc = 2'd1;
  localparam logic [1:0] st_run  = 2'd2;

  logic [1:0]       state;
  logic [cnt_w-1:0] cnt;
  logic             pending;

  logic signed [data_width-1:0] left_tgt,   right_tgt;
  logic signed [data_width-1:0] left_pend,  right_pend;
  logic signed [acc_w-1:0]      left_acc,   right_acc;
  logic signed [dlt_w-1:0]      left_delta, right_delta;

  logic signed [acc_w-1:0] left_acc_nx, right_acc_nx;
  logic signed [acc_w-1:0] left_sh,     right_sh;

  // Accumulator only moves in RUN; elsewhere the held value is re-emitted.
  always_comb begin
    left_acc_nx  = left_acc;
    right_acc_nx = right_acc;
    if (state == st_run) begin
      left_acc_nx  = left_acc  + acc_w'(left_delta);
      right_acc_nx = right_acc + acc_w'(right_delta);
    end
  end

  assign left_sh  = left_acc_nx  >>> log2_ratio;
  assign right_sh = right_acc_nx >>> log2_ratio;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= st_idle;
      cnt         <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      sample_out  <= 1'b0;
      left_out    <= '0;
      right_out   <= '0;
      left_tgt    <= '0;
      right_tgt   <= '0;
      left_pend   <= '0;
      right_pend  <= '0;
      left_acc    <= '0;
      right_acc   <= '0;
      left_delta  <= '0;
      right_delta <= '0;
    end else begin
      sample_out <= cen_out;
      if (cen_out) begin
        left_out  <= left_sh[data_width-1:0];
        right_out <= right_sh[data_width-1:0];
      end

      case (state)
        st_idle: begin
          if (pending || sample_in) state <= st_calc;
        end
        st_calc: begin
          left_acc    <= acc_w'(left_tgt)  <<< log2_ratio;
          right_acc   <= acc_w'(right_tgt) <<< log2_ratio;
          left_delta  <= dlt_w'(left_pend)  - dlt_w'(left_tgt);
          right_delta <= dlt_w'(right_pend) - dlt_w'(right_tgt);
          left_tgt    <= left_pend;
          right_tgt   <= right_pend;
          cnt         <= '0;
          state       <= st_run;
        end
        st_run: begin
          if (cen_out) begin
            left_acc  <= left_acc_nx;
            right_acc <= right_acc_nx;
            cnt       <= cnt + cnt_w'(1);
            if (cnt == cnt_last) state <= st_idle;
          end
        end
        default: state <= st_idle;
      endcase

      // A capture during CALC is not a loss: the old pending word is consumed that cycle.
      if (sample_in) begin
        left_pend  <= left_in;
        right_pend <= right_in;
        pending    <= 1'b1;
        if (pending && state != st_calc) overrun <= 1'b1;
      end else if (state == st_calc) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jt51_interp.sv
// tb/tb_jt51_interp.sv - randomized and directed bench for jt51_interp against a ramp model
module tb_jt51_interp;

  localparam int DW = 12;
  localparam int L  = 2;
  localparam int R  = 4;
  localparam int P_IDLE = 0, P_CALC = 1, P_RUN = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sample_in = 1'b0;
  logic                 cen_out = 1'b0;
  logic signed [DW-1:0] left_in = '0;
  logic signed [DW-1:0] right_in = '0;
  logic signed [DW-1:0] left_out;
  logic signed [DW-1:0] right_out;
  logic                 sample_out;
  logic                 overrun;

  jt51_interp #(.data_width(DW), .log2_ratio(L)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .left_in(left_in), .right_in(right_in),
    .cen_out(cen_out), .left_out(left_out), .right_out(right_out),
    .sample_out(sample_out), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: each ramp is described by its endpoints; output k of R is from + floor(k*(to-from)/R).
  int m_tgt[2], m_pv[2], m_from[2], m_to[2], m_out[2];
  bit m_pend, m_sout, m_ovr;
  int m_phase, m_k;
  int got_l[$], got_r[$];

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int ramp_value(input int ch, input int k);
    return m_from[ch] + floor_div(k * (m_to[ch] - m_from[ch]), R);
  endfunction

  task automatic model_edge(input bit r_, input bit si, input int li, input int ri, input bit co);
    bit old_pend;
    int old_phase;
    if (r_) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_tgt[ch] = 0; m_pv[ch] = 0; m_from[ch] = 0; m_to[ch] = 0; m_out[ch] = 0;
      end
      m_pend = 0; m_sout = 0; m_ovr = 0; m_phase = P_IDLE; m_k = 0;
      return;
    end
    old_pend = m_pend;
    old_phase = m_phase;
    m_sout = co;
    if (co)
      for (int ch = 0; ch < 2; ch++)
        m_out[ch] = (m_phase == P_RUN) ? ramp_value(ch, m_k + 1) : m_to[ch];
    case (m_phase)
      P_IDLE: if (m_pend || si) m_phase = P_CALC;
      P_CALC: begin
        for (int ch = 0; ch < 2; ch++) begin
          m_from[ch] = m_tgt[ch]; m_to[ch] = m_pv[ch]; m_tgt[ch] = m_pv[ch];
        end
        m_k = 0; m_pend = 0; m_phase = P_RUN;
      end
      default: if (co) begin
        m_k++;
        if (m_k == R) m_phase = P_IDLE;
      end
    endcase
    if (si) begin
      if (old_pend && old_phase != P_CALC) m_ovr = 1;
      m_pv[0] = li; m_pv[1] = ri; m_pend = 1;
    end
  endtask

  task automatic cyc(input bit r_, input bit si, input int li, input int ri, input bit co);
    rst = r_; sample_in = si; cen_out = co;
    left_in = DW'(li); right_in = DW'(ri);
    @(posedge clk);
    model_edge(r_, si, li, ri, co);
    @(negedge clk);
    check("left_out", int'(left_out), m_out[0]);
    check("right_out", int'(right_out), m_out[1]);
    check("sample_out", int'(sample_out), int'(m_sout));
    check("overrun", int'(overrun), int'(m_ovr));
    if (sample_out) begin
      got_l.push_back(int'(left_out));
      got_r.push_back(int'(right_out));
    end
  endtask

  task automatic idle_cycles(input int n, input bit alt_cen);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, alt_cen ? (i % 2 == 0) : 1'b0);
  endtask

  int exp_l[6] = '{25, 50, 75, 100, 100, 100};
  int exp_r[6] = '{-1, -2, -3, -3, -3, -3};
  int viol;

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 55, 55, 1);
    check("rst_left", int'(left_out), 0);
    check("rst_sample_out", int'(sample_out), 0);
    check("rst_overrun", int'(overrun), 0);

    // Basic ramp, including floor behaviour on a negative step
    got_l.delete(); got_r.delete();
    cyc(0, 1, 100, -3, 0);
    cyc(0, 0, 0, 0, 0);
    idle_cycles(12, 1);
    check("d1_count", got_l.size(), 6);
    for (int i = 0; i < 6 && i < got_l.size(); i++) begin
      check("d1_left", got_l[i], exp_l[i]);
      check("d1_right", got_r[i], exp_r[i]);
    end

    // Full-scale swing
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 2047, 0, 0);
    idle_cycles(12, 1);
    check("d2_top", int'(left_out), 2047);
    got_l.delete(); got_r.delete();
    cyc(0, 1, -2048, 0, 0);
    cyc(0, 0, 0, 0, 0);
    idle_cycles(10, 1);
    viol = 0;
    for (int i = 1; i < got_l.size(); i++) if (got_l[i] > got_l[i-1]) viol++;
    check("d2_monotonic", viol, 0);
    check("d2_first", (got_l.size() > 0) ? got_l[0] : 9999, 1023);
    check("d2_end", int'(left_out), -2048);

    // Two samples during one ramp, the second together with a cen_out step
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 100, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("d3_step1", int'(left_out), 25);
    cyc(0, 1, 200, 0, 0);
    cyc(0, 1, 300, 0, 1);
    check("d3_step2", int'(left_out), 50);
    check("d3_overrun", int'(overrun), 1);
    idle_cycles(30, 1);
    check("d3_final", int'(left_out), 300);
    check("d3_overrun_sticky", int'(overrun), 1);

    // Reset in the middle of a ramp
    cyc(0, 1, 1000, -1000, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    check("d4_left", int'(left_out), 0);
    check("d4_sample_out", int'(sample_out), 0);
    check("d4_overrun", int'(overrun), 0);
    got_l.delete(); got_r.delete();
    cyc(0, 1, 40, 0, 0);
    cyc(0, 0, 0, 0, 0);
    idle_cycles(8, 1);
    check("d4_fresh", (got_l.size() > 0) ? got_l[0] : 9999, 10);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit r_, si, co;
      r_ = ($urandom_range(0, 599) == 0);
      si = ($urandom_range(0, 13) == 0) || (i % 700 < 6);
      co = ($urandom_range(0, 3) == 0);
      cyc(r_, si, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, co);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jt51_interp.md
JT51_INTERP -- requirements
Module: jt51_interp

Interface
REQ-001 SHALL have parameter data_width, default 12, meaning sample width, matching the FIR output width.
REQ-002 SHALL have parameter log2_ratio, default 2, meaning upsampling ratio R = 2^log2_ratio.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sample_in  input  1  one-cycle strobe; left_in/right_in valid (the FIR sample_out).
REQ-006 SHALL have port left_in  input  data_width  signed left sample.
REQ-007 SHALL have port right_in  input  data_width  signed right sample.
REQ-008 SHALL have port cen_out  input  1  output-rate clock enable, nominally R times the input rate.
REQ-009 SHALL have port left_out  output  data_width  signed interpolated left sample, registered.
REQ-010 SHALL have port right_out  output  data_width  signed interpolated right sample, registered.
REQ-011 SHALL have port sample_out  output  1  one-cycle pulse; left_out/right_out updated.
REQ-012 SHALL have port overrun  output  1  sticky flag; a pending sample was overwritten.

Function
REQ-013 SHALL keep per channel: target register (last applied input), pending register plus pending flag, signed accumulator of data_width+log2_ratio bits, and signed delta of data_width+1 bits.
REQ-014 SHALL, on sample_in, copy left_in/right_in into the pending registers and set pending; if pending is already set, the new data SHALL overwrite it and overrun SHALL be set.
REQ-015 SHALL implement states IDLE, CALC and RUN.
REQ-016 IDLE: if pending, go to CALC next cycle; otherwise hold outputs.
REQ-017 CALC (one cycle): acc = target<<log2_ratio; delta = pending - target (full width, no overflow); target = pending; clear pending (unless sample_in in same cycle re-sets it); step counter = 0; go to RUN.
REQ-018 RUN: on each cen_out, acc += sign-extended delta, counter++; when counter reaches R-1 on that step, go to IDLE (acc then equals target<<log2_ratio exactly).
REQ-019 Outputs SHALL be acc>>>log2_ratio (arithmetic shift, truncation toward minus infinity), registered on the cen_out cycle.
REQ-020 sample_out SHALL pulse one cycle after every cen_out in every state; in IDLE/CALC the held value is re-emitted, so output rate is fixed by cen_out only.
REQ-021 Latency: sample_in at cycle t in IDLE gives CALC at t+1 and RUN from t+2; the first stepped output follows the first cen_out at or after t+2.
REQ-022 A sample arriving during RUN SHALL wait as pending; the ramp in progress is never truncated.
REQ-023 Simultaneous sample_in and cen_out SHALL both take effect: capture per REQ-014 and step per current state.
REQ-024 Both channels SHALL share state and counter and step in lockstep.

Reset
REQ-025 While rst is high: state IDLE, accumulators, targets, pending registers, delta, counter, left_out, right_out = 0; pending, sample_out, overrun = 0.
REQ-026 rst mid-RUN SHALL abandon the ramp; the next cycle starts from the reset values with no sample_out.

Structure
REQ-027 No shared package; state encodings are local parameters, and widths derive from the parameters.
REQ-028 SHALL be a single module with no sub-modules; per-channel datapath duplicated in place.

Verification
REQ-029 log2_ratio=2, target 0, left_in=100 -> next four cen_out give left_out 25,50,75,100, then 100 held with sample_out still pulsing.
REQ-030 target 0, left_in=-3 -> outputs -1,-2,-3,-3 (floor shift) and final acc = -12.
REQ-031 Full-scale swing 2047 to -2048 (data_width 12) -> delta -4095, monotonic ramp, no wrap, ends at -2048.
REQ-032 Two sample_in during one RUN -> second value applied next, overrun=1 and stays 1 until rst.
REQ-033 sample_in and cen_out in the same cycle during RUN -> step taken and pending set, both observed.
REQ-034 rst asserted mid-ramp -> all outputs 0 next cycle; a fresh sample ramps from 0.
